// File: rtl/axis_ram_streamer_pkg.sv
// Shared types for the RAM-to-stream reader: state encoding of the command/stream controller.
`default_nettype none

package axis_ram_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } streamer_state_e;

endpackage

`default_nettype wire

// File: rtl/axis_ram_streamer_if.sv
// AXI Stream bundle (tvalid/tready/tdata) with manager and subordinate views.
`default_nettype none

interface axis_ram_streamer_if #(
    parameter int TDATA_WIDTH = 8
);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

`default_nettype wire

// File: rtl/axis_ram_streamer_slice.sv
// Registered AXI Stream output stage: loads a word on request, empties on handshake, flushes on clear.
`default_nettype none

module axis_ram_streamer_slice #(
    parameter int TDATA_WIDTH = 8
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   load_i,
    input  wire logic                   clear_i,
    input  wire logic                   tready_i,
    input  wire logic [TDATA_WIDTH-1:0] data_i,
    output logic                        tvalid_o,
    output logic [TDATA_WIDTH-1:0]      tdata_o
);

    logic                   tvalid_q;
    logic [TDATA_WIDTH-1:0] tdata_q;

    // clear drops a pending word outright; tdata keeps its last value since tvalid gates it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
        end else if (clear_i) begin
            tvalid_q <= 1'b0;
        end else if (load_i) begin
            tvalid_q <= 1'b1;
            tdata_q  <= data_i;
        end else if (tready_i) begin
            tvalid_q <= 1'b0;
        end
    end

    assign tvalid_o = tvalid_q;
    assign tdata_o  = tdata_q;

endmodule

`default_nettype wire

// File: rtl/axis_ram_streamer.sv
// Drains cmd_len+1 words from an async-read RAM, starting at cmd_addr, onto an AXI Stream port.
// Optional abort input is compiled in with AXIS_RAM_STREAMER_ABORT_EN.
`default_nettype none

module axis_ram_streamer
    import axis_ram_streamer_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int LEN_WIDTH   = 8,
    parameter int TDATA_WIDTH = 8
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   cmd_valid,
    output logic                        cmd_ready,
    input  wire logic [ADDR_WIDTH-1:0]  cmd_addr,
    input  wire logic [LEN_WIDTH-1:0]   cmd_len,
    output logic [ADDR_WIDTH-1:0]       ram_raddr,
    input  wire logic [TDATA_WIDTH-1:0] ram_rdata,
    axis_ram_streamer_if.master         axis_mif,
    output logic                        done
`ifdef AXIS_RAM_STREAMER_ABORT_EN
    ,
    input  wire logic                   abort
`endif
);

    streamer_state_e       state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remain_q, remain_d;
    logic                  done_q, done_d;
    logic                  w_abort;
    logic                  w_load;
    logic                  w_tvalid;
    logic                  w_out_hs;

`ifdef AXIS_RAM_STREAMER_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_load   = (state_q == ST_STREAM) && !w_abort && (!w_tvalid || axis_mif.tready);
    assign w_out_hs = w_tvalid && axis_mif.tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d  = ST_STREAM;
                    addr_d   = cmd_addr;
                    remain_d = cmd_len;
                end
            end
            ST_STREAM: begin
                if (w_load) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    // remain_q==0 marks the last word; park the counter at zero
                    if (remain_q == '0) begin
                        state_d = ST_DRAIN;
                    end else begin
                        remain_d = remain_q - LEN_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (w_out_hs) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (w_abort) begin
            state_d  = ST_IDLE;
            addr_d   = '0;
            remain_d = '0;
            done_d   = 1'b0;
        end
    end

    axis_ram_streamer_slice #(
        .TDATA_WIDTH (TDATA_WIDTH)
    ) u_slice (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (w_load),
        .clear_i  (w_abort),
        .tready_i (axis_mif.tready),
        .data_i   (ram_rdata),
        .tvalid_o (w_tvalid),
        .tdata_o  (axis_mif.tdata)
    );

    assign axis_mif.tvalid = w_tvalid;
    assign cmd_ready       = (state_q == ST_IDLE);
    assign ram_raddr       = addr_q;
    assign done            = done_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_ram_streamer.sv
// Self-checking bench for axis_ram_streamer: command table plus random commands against a queue model.
`default_nettype none
`timescale 1ns/1ps

module tb_axis_ram_streamer;

    localparam int AW = 4;
    localparam int LW = 8;
    localparam int DW = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        bit            rnd;
        int            exp_beats;
        logic [AW-1:0] exp_last;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata;
    logic          done;
`ifdef AXIS_RAM_STREAMER_ABORT_EN
    logic          abort = 1'b0;
`endif

    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    axis_ram_streamer_if #(.TDATA_WIDTH(DW)) axis_bus ();

    assign ram_rdata = mem[ram_raddr];

    axis_ram_streamer #(
        .ADDR_WIDTH  (AW),
        .LEN_WIDTH   (LW),
        .TDATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata),
        .axis_mif  (axis_bus.master),
        .done      (done)
`ifdef AXIS_RAM_STREAMER_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_cmd(input vec_t v);
        logic [DW-1:0] expq[$];
        logic [DW-1:0] sdata = '0;
        logic [DW-1:0] last_data = '0;
        logic [DW-1:0] e;
        bit            stall = 1'b0;
        int            beats = 0;
        int            first = -1;
        int            last = -1;
        int            n = 0;
        int            budget;
        for (int i = 0; i <= int'(v.len); i++)
            expq.push_back(mem[(int'(v.addr) + i) % (1 << AW)]);
        budget = (int'(v.len) + 1) * 8 + 20;
        while (!cmd_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = ~v.addr;
        cmd_len   = ~v.len;
        axis_bus.tready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        // address registered at the handshake; word is presented one cycle later
        chk("tvalid_low_after_cmd", {31'd0, axis_bus.tvalid}, 32'd0);
        chk("cmd_ready_low_busy", {31'd0, cmd_ready}, 32'd0);
        n = 0;
        while (beats < v.exp_beats && n < budget) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("first_tvalid_latency", {31'd0, axis_bus.tvalid}, 32'd1);
            if (stall) begin
                chk("stall_tvalid_hold", {31'd0, axis_bus.tvalid}, 32'd1);
                chk("stall_tdata_hold", 32'(axis_bus.tdata), 32'(sdata));
            end
            chk("done_low_busy", {31'd0, done}, 32'd0);
            axis_bus.tready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (axis_bus.tvalid && axis_bus.tready) begin
                e = (expq.size() > 0) ? expq.pop_front() : '0;
                chk("beat_data", 32'(axis_bus.tdata), 32'(e));
                beats++;
                if (first < 0) first = n;
                last      = n;
                last_data = axis_bus.tdata;
                stall     = 1'b0;
            end else if (axis_bus.tvalid) begin
                stall = 1'b1;
                sdata = axis_bus.tdata;
            end else begin
                stall = 1'b0;
            end
        end
        chk("beat_count", 32'(beats), 32'(v.exp_beats));
        chk("last_beat_data", 32'(last_data), 32'(mem[v.exp_last]));
        if (!v.rnd) chk("consecutive_span", 32'(last - first), 32'(v.exp_beats - 1));
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("cmd_ready_at_done", {31'd0, cmd_ready}, 32'd1);
        chk("tvalid_low_at_done", {31'd0, axis_bus.tvalid}, 32'd0);
    endtask

    initial begin
        vec_t tbl[5];
        vec_t rv;
        int   n;
        int   hs;

        axis_bus.tready = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = {8'(i), 8'($urandom)};

        tbl[0] = '{addr: 4'd3,  len: 8'd3,   rnd: 1'b0, exp_beats: 4,   exp_last: 4'd6};
        tbl[1] = '{addr: 4'd14, len: 8'd3,   rnd: 1'b0, exp_beats: 4,   exp_last: 4'd1};
        tbl[2] = '{addr: 4'd9,  len: 8'd0,   rnd: 1'b0, exp_beats: 1,   exp_last: 4'd9};
        tbl[3] = '{addr: 4'd2,  len: 8'd1,   rnd: 1'b0, exp_beats: 2,   exp_last: 4'd3};
        tbl[4] = '{addr: 4'd5,  len: 8'd255, rnd: 1'b1, exp_beats: 256, exp_last: 4'd4};

        @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_tvalid", {31'd0, axis_bus.tvalid}, 32'd0);
        chk("rst_tdata", 32'(axis_bus.tdata), 32'd0);
        chk("rst_raddr", 32'(ram_raddr), 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // rows run back to back: each new command is issued in the previous done cycle
        for (int i = 0; i < 5; i++) run_cmd(tbl[i]);

        for (int i = 0; i < 4; i++) begin
            rv.addr      = 4'($urandom);
            rv.len       = 8'($urandom_range(0, 20));
            rv.rnd       = 1'b1;
            rv.exp_beats = int'(rv.len) + 1;
            rv.exp_last  = 4'(int'(rv.addr) + int'(rv.len));
            run_cmd(rv);
        end

`ifdef AXIS_RAM_STREAMER_ABORT_EN
        axis_bus.tready = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr  = 4'd4;
        cmd_len   = 8'd5;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!axis_bus.tvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_setup_tvalid", {31'd0, axis_bus.tvalid}, 32'd1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_tvalid", {31'd0, axis_bus.tvalid}, 32'd0);
        chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("abort_done", {31'd0, done}, 32'd0);
        axis_bus.tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done}, 32'd0);
            chk("abort_stays_idle", {31'd0, axis_bus.tvalid}, 32'd0);
        end
        rv = '{addr: 4'd11, len: 8'd2, rnd: 1'b0, exp_beats: 3, exp_last: 4'd13};
        run_cmd(rv);
`endif

        axis_bus.tready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = 4'd0;
        cmd_len   = 8'd7;
        @(negedge clk);
        cmd_valid = 1'b0;
        hs = 0;
        n  = 0;
        while (hs < 2 && n < 20) begin
            @(negedge clk);
            n++;
            if (axis_bus.tvalid && axis_bus.tready) hs++;
        end
        chk("reset_setup_beats", 32'(hs), 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", {31'd0, axis_bus.tvalid}, 32'd0);
        chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_raddr", 32'(ram_raddr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rv = '{addr: 4'd7, len: 8'd1, rnd: 1'b0, exp_beats: 2, exp_last: 4'd8};
        run_cmd(rv);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
